sevenseg_ndigit_scanner: RTL and testbench

SEVENSEG_NDIGIT_SCANNER -- requirements
Module: sevenseg_ndigit_scanner

---
 rtl/sevenseg_pkg.sv | 30 +++
 rtl/hex_to_seg7.sv | 14 +
 rtl/sevenseg_ndigit_scanner.sv | 159 +++++++++++++++
 tb/tb_sevenseg_ndigit_scanner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: the hex glyph
// table (active-low {g,f,e,d,c,b,a}), the blank pattern and the anode-off word.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Wide enough for the largest legal digit count; callers slice what they need.
  localparam logic [15:0] AN_ALL_OFF = 16'hFFFF;

  // Element 0 is the glyph for nibble 0, element 15 the glyph for nibble F.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E,   // F
    7'h06,   // E
    7'h21,   // d
    7'h46,   // C
    7'h03,   // b
    7'h08,   // A
    7'h10,   // 9
    7'h00,   // 8
    7'h78,   // 7
    7'h02,   // 6
    7'h12,   // 5
    7'h19,   // 4
    7'h30,   // 3
    7'h24,   // 2
    7'h79,   // 1
    7'h40    // 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg7
  import sevenseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Straight table lookup, no registers.
  always_comb begin
    seg = HEX_SEG_TABLE[hex];
  end

endmodule

// File: rtl/sevenseg_ndigit_scanner.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered display
// data, leading-zero suppression, PWM brightness and anode dead time.
module sevenseg_ndigit_scanner
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int DEAD_CYC   = 2,
  parameter int BRIGHT_W   = 4
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              cathode,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [PRESC_W-1:0]    DEAD_END   = PRESC_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = AN_ALL_OFF[NUM_DIGITS-1:0];

  logic [PRESC_W-1:0]      presc;
  logic [IDX_W-1:0]        idx;
  logic [BRIGHT_W-1:0]     pwm_cnt;
  logic                    presc_tc;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] pend_value;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_blank;
  logic                    pend_flag;
  logic [4*NUM_DIGITS-1:0] act_value;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    lz_run;
  logic [3:0]              cur_nib;
  logic [6:0]              cur_seg;
  logic                    anode_on;
  logic [6:0]              cathode_d;
  logic                    dp_n_d;
  logic [NUM_DIGITS-1:0]   an_d;

  assign presc_tc = (presc == PRESC_LAST);
  assign wrap     = presc_tc && (idx == IDX_LAST);
  assign cur_nib  = act_value[4*idx +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .hex (cur_nib),
    .seg (cur_seg)
  );

  // Slot prescaler, digit index and free-running PWM counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc   <= '0;
      idx     <= '0;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
      if (presc_tc) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        presc <= presc + PRESC_W'(1);
      end
    end
  end

  // Double buffer: loads land in pending and only reach active at a frame
  // boundary, so one frame never shows a mix of two loads. A load in the wrap
  // cycle itself bypasses pending and leaves nothing queued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_flag  <= 1'b0;
      act_value  <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else if (wrap && load) begin
      act_value  <= value;
      act_dp     <= dp;
      act_blank  <= blank;
      pend_value <= value;
      pend_dp    <= dp;
      pend_blank <= blank;
      pend_flag  <= 1'b0;
    end else begin
      if (wrap && pend_flag) begin
        act_value <= pend_value;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
        pend_flag <= 1'b0;
      end
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp;
        pend_blank <= blank;
        pend_flag  <= 1'b1;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while nibbles stay zero;
  // digit 0 is never part of the run so a value of zero still shows "0".
  always_comb begin
    lz_mask = '0;
    lz_run  = lz_en;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run     = lz_run && (act_value[4*k +: 4] == 4'h0);
      lz_mask[k] = lz_run;
    end
  end

  // Next output values: anode gated by dead time and PWM duty, glyph blanked
  // on request or suppression while the decimal point keeps following dp.
  always_comb begin
    anode_on  = (presc >= DEAD_END) &&
                ((brightness == '1) || (pwm_cnt < brightness));
    an_d      = AN_OFF;
    if (anode_on) begin
      an_d[idx] = 1'b0;
    end
    cathode_d = (act_blank[idx] || lz_mask[idx]) ? SEG_BLANK : cur_seg;
    dp_n_d    = ~act_dp[idx];
  end

  // Anode, cathode and dp all come from one register stage so the glyph and
  // the anode that lights it always change on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cathode    <= SEG_BLANK;
      dp_n       <= 1'b1;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      cathode    <= cathode_d;
      dp_n       <= dp_n_d;
      an         <= an_d;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_sevenseg_ndigit_scanner.sv
// Directed, table-driven bench for a 4-digit scanner with 8-cycle slots,
// one dead cycle per slot and 2-bit brightness. Each table row describes one
// whole frame: live controls, expected glyphs and an optional load for later.
module tb_sevenseg_ndigit_scanner;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int DC = 1;
  localparam int BW = 2;
  localparam int FRAME = ND * SD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp = '0;
  logic [3:0]    blank = '0;
  logic          lz_en = 1'b0;
  logic          load = 1'b0;
  logic [BW-1:0] brightness = '1;
  logic [6:0]    cathode;
  logic          dp_n;
  logic [3:0]    an;
  logic          frame_done;

  int num_vectors = 0;
  int num_miscompares = 0;

  typedef struct {
    logic [1:0]      bright;
    logic            lz;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
    int              load_k;
    logic [15:0]     ld_value;
    logic [3:0]      ld_dp;
    logic [3:0]      ld_blank;
  } frame_vec_t;

  frame_vec_t vecs[10];
  frame_vec_t zero_frame;

  always #5 clk = ~clk;

  sevenseg_ndigit_scanner #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .DEAD_CYC   (DC),
    .BRIGHT_W   (BW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp         (dp),
    .blank      (blank),
    .lz_en      (lz_en),
    .load       (load),
    .brightness (brightness),
    .cathode    (cathode),
    .dp_n       (dp_n),
    .an         (an),
    .frame_done (frame_done)
  );

  // Expected anode word for frame position p (slot = p/8, prescaler = p%8).
  // PWM and prescaler both start at zero after reset and 8 is a multiple of 4,
  // so the PWM phase at position p is simply p%4.
  function automatic logic [3:0] expAn(input int p, input logic [1:0] br);
    int  presc = p % SD;
    int  d     = p / SD;
    logic on;
    on = (presc >= DC) && ((br == 2'b11) || ((p % 4) < int'(br)));
    return on ? ~(4'b0001 << d) : 4'hF;
  endfunction

  task automatic applyStimulus(input logic ld, input logic [15:0] v,
                               input logic [3:0] d, input logic [3:0] b);
    load = ld;
    if (ld) begin
      value = v;
      dp    = d;
      blank = b;
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_an,
                             input logic exp_fd, input logic [6:0] exp_cath,
                             input logic exp_dpn, input logic chk_seg);
    num_vectors++;
    if (an !== exp_an) begin
      num_miscompares++;
      $display("[TB] FAIL %s an: got %b expected %b", name, an, exp_an);
    end
    if (frame_done !== exp_fd) begin
      num_miscompares++;
      $display("[TB] FAIL %s frame_done: got %b expected %b", name, frame_done, exp_fd);
    end
    if (chk_seg) begin
      if (cathode !== exp_cath) begin
        num_miscompares++;
        $display("[TB] FAIL %s cathode: got %h expected %h", name, cathode, exp_cath);
      end
      if (dp_n !== exp_dpn) begin
        num_miscompares++;
        $display("[TB] FAIL %s dp_n: got %b expected %b", name, dp_n, exp_dpn);
      end
    end
  endtask

  // Called on the negedge where frame_done is high; checks the whole next
  // frame and ends on the negedge where the following frame_done is high.
  task automatic runFrame(input int fi, input frame_vec_t fv);
    logic [3:0] ea;
    int p;
    int d;
    brightness = fv.bright;
    lz_en      = fv.lz;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      p  = k - 1;
      d  = p / SD;
      ea = expAn(p, fv.bright);
      checkOutput($sformatf("frame%0d pos%0d", fi, p), ea, (k == FRAME),
                  fv.seg[d], fv.dpn[d], (ea != 4'hF));
      applyStimulus(k == fv.load_k, fv.ld_value, fv.ld_dp, fv.ld_blank);
    end
  endtask

  // Counts negedges from reset release until frame_done; always bounded.
  task automatic waitFirstFrame(input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      if (i == 1) applyStimulus(1'b0, '0, '0, '0);
      if (frame_done) begin
        n = i;
        break;
      end
    end
    num_vectors++;
    if (n != FRAME) begin
      num_miscompares++;
      $display("[TB] FAIL %s first frame_done latency: got %0d expected %0d", name, n, FRAME);
    end
  endtask

  initial begin
    vecs[0] = '{bright:2'd3, lz:1'b0, seg:{7'h79, 7'h24, 7'h30, 7'h19}, dpn:4'hF,
                load_k:12, ld_value:16'hAAAA, ld_dp:4'h0, ld_blank:4'h0};
    vecs[1] = '{bright:2'd3, lz:1'b0, seg:{7'h08, 7'h08, 7'h08, 7'h08}, dpn:4'hF,
                load_k:31, ld_value:16'h00F0, ld_dp:4'b0100, ld_blank:4'h0};
    vecs[2] = '{bright:2'd3, lz:1'b0, seg:{7'h40, 7'h40, 7'h0E, 7'h40}, dpn:4'b1011,
                load_k:12, ld_value:16'h0000, ld_dp:4'h0, ld_blank:4'h0};
    vecs[3] = '{bright:2'd3, lz:1'b1, seg:{7'h7F, 7'h7F, 7'h7F, 7'h40}, dpn:4'hF,
                load_k:12, ld_value:16'h0105, ld_dp:4'h0, ld_blank:4'h0};
    vecs[4] = '{bright:2'd3, lz:1'b1, seg:{7'h7F, 7'h79, 7'h40, 7'h12}, dpn:4'hF,
                load_k:12, ld_value:16'h5678, ld_dp:4'b0010, ld_blank:4'b0010};
    vecs[5] = '{bright:2'd1, lz:1'b1, seg:{7'h12, 7'h02, 7'h7F, 7'h00}, dpn:4'b1101,
                load_k:-1, ld_value:16'h0000, ld_dp:4'h0, ld_blank:4'h0};
    vecs[6] = '{bright:2'd0, lz:1'b1, seg:{7'h12, 7'h02, 7'h7F, 7'h00}, dpn:4'b1101,
                load_k:-1, ld_value:16'h0000, ld_dp:4'h0, ld_blank:4'h0};
    vecs[7] = '{bright:2'd2, lz:1'b1, seg:{7'h12, 7'h02, 7'h7F, 7'h00}, dpn:4'b1101,
                load_k:12, ld_value:16'h9BCD, ld_dp:4'h0, ld_blank:4'h0};
    vecs[8] = '{bright:2'd3, lz:1'b0, seg:{7'h10, 7'h03, 7'h46, 7'h21}, dpn:4'hF,
                load_k:12, ld_value:16'h0E07, ld_dp:4'h0, ld_blank:4'h0};
    vecs[9] = '{bright:2'd3, lz:1'b1, seg:{7'h7F, 7'h06, 7'h40, 7'h78}, dpn:4'hF,
                load_k:-1, ld_value:16'h0000, ld_dp:4'h0, ld_blank:4'h0};
    zero_frame = '{bright:2'd3, lz:1'b0, seg:{7'h40, 7'h40, 7'h40, 7'h40}, dpn:4'hF,
                   load_k:-1, ld_value:16'h0000, ld_dp:4'h0, ld_blank:4'h0};

    // Power-on reset values.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset", 4'hF, 1'b0, 7'h7F, 1'b1, 1'b1);

    // Release reset and load 1234 during the first (partial) frame.
    $display("[TB] releasing reset, loading 1234");
    rst_n      = 1'b1;
    brightness = 2'd3;
    applyStimulus(1'b1, 16'h1234, 4'h0, 4'h0);
    waitFirstFrame("post-reset");

    for (int i = 0; i < 10; i++) begin
      runFrame(i, vecs[i]);
    end

    // Mid-slot reset at digit 2, prescaler 5, with a load still pending.
    $display("[TB] mid-slot reset with pending load");
    brightness = 2'd3;
    lz_en      = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      applyStimulus(k == 12, 16'h4321, 4'hF, 4'h0);
    end
    rst_n = 1'b0;
    for (int k = 22; k <= 36; k++) begin
      @(negedge clk);
      checkOutput($sformatf("mid-slot reset cyc%0d", k), 4'hF, 1'b0, 7'h7F, 1'b1, 1'b1);
    end

    // Banks and pending flag were cleared, so the next frame shows zeros.
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, '0, '0);
    waitFirstFrame("after mid-slot reset");
    runFrame(10, zero_frame);

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
